// File: rtl/sync_memory_module_if.sv
// Request/completion bus between the CPU control FSM and sync_memory_module.
// Optional parity signals exist only when MEM_PARITY_EN is defined.
interface sync_memory_module_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic [AW-1:0] address;
  logic          read;
  logic          write;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          ready;
  logic          valid;
  logic          addr_err;
`ifdef MEM_PARITY_EN
  logic          inject_err;
  logic          parity_err;

  modport master (
    output address, read, write, data_in, inject_err,
    input  data_out, ready, valid, addr_err, parity_err
  );
  modport slave (
    input  address, read, write, data_in, inject_err,
    output data_out, ready, valid, addr_err, parity_err
  );
`else
  modport master (
    output address, read, write, data_in,
    input  data_out, ready, valid, addr_err
  );
  modport slave (
    input  address, read, write, data_in,
    output data_out, ready, valid, addr_err
  );
`endif
endinterface

// File: rtl/sync_memory_module.sv
// Clocked unified program/data memory with wait states, valid/ready handshake and range check.
// Define MEM_PARITY_EN to add an even-parity bit per word with error injection and reporting.
module sync_memory_module #(
  parameter int    DW          = 8,
  parameter int    DEPTH       = 16,
  parameter int    AW          = 4,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sync_memory_module_if.slave  bus
);

`ifdef MEM_PARITY_EN
  localparam int MW = DW + 1;
`else
  localparam int MW = DW;
`endif

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_next;
  logic [3:0]    count, count_next;
  logic          done;

  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] rd_word;
  logic [MW-1:0] wr_word;

  logic          in_range;
  logic          accept;
  logic          acc_read;
  logic [DW-1:0] acc_data;
  logic [DW-1:0] pend_data;
  logic          pend_read;
  logic          pend_err;
  logic [DW-1:0] fin_data;
  logic          fin_read;
  logic          fin_err;

  assign bus.ready = (state == IDLE);
  assign accept    = rst_n && bus.ready && (bus.read || bus.write);
  assign in_range  = int'(bus.address) < DEPTH;
  assign acc_read  = bus.read && !bus.write;
  assign rd_word   = mem[bus.address];
  assign acc_data  = in_range ? rd_word[DW-1:0] : '0;

`ifdef MEM_PARITY_EN
  logic acc_perr, pend_perr, fin_perr;
  // A correctly stored word has even parity over all MW bits.
  assign acc_perr = in_range && (^rd_word);
  assign wr_word  = {(^bus.data_in) ^ bus.inject_err, bus.data_in};
  assign fin_perr = (state == IDLE) ? acc_perr : pend_perr;
`else
  assign wr_word  = bus.data_in;
`endif

  always_ff @(posedge clk) begin
    if (accept && bus.write && in_range) mem[bus.address] <= wr_word;
  end

  // With zero wait states the block never leaves IDLE and completes on the accept edge.
  always_comb begin
    state_next = state;
    count_next = count;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            done = 1'b1;
          end else begin
            state_next = BUSY;
            count_next = 4'(WAIT_STATES - 1);
          end
        end
      end
      BUSY: begin
        if (count == 4'd0) begin
          state_next = IDLE;
          done       = 1'b1;
        end else begin
          count_next = count - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign fin_read = (state == IDLE) ? acc_read  : pend_read;
  assign fin_err  = (state == IDLE) ? !in_range : pend_err;
  assign fin_data = (state == IDLE) ? acc_data  : pend_data;

  // Read data is frozen at accept so the completion reports what was there at that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      count        <= 4'd0;
      pend_data    <= '0;
      pend_read    <= 1'b0;
      pend_err     <= 1'b0;
      bus.data_out <= '0;
      bus.valid    <= 1'b0;
      bus.addr_err <= 1'b0;
`ifdef MEM_PARITY_EN
      pend_perr      <= 1'b0;
      bus.parity_err <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      count     <= count_next;
      bus.valid <= done;
      if (accept) begin
        pend_data <= acc_data;
        pend_read <= acc_read;
        pend_err  <= !in_range;
`ifdef MEM_PARITY_EN
        pend_perr <= acc_perr;
`endif
      end
      bus.addr_err <= done && fin_err;
      if (done && fin_read) bus.data_out <= fin_data;
`ifdef MEM_PARITY_EN
      bus.parity_err <= done && fin_read && fin_perr;
`endif
    end
  end

endmodule
